// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiply path.
// Provides: FSM state encoding, [N,Z,C,V] flag bit positions, default width.
// Imported by mul_seq_ctrl and mul_flag_gen.
package mul_pkg;

    localparam int WIDTH_DEF = 32;

    // Flag nibble layout [N,Z,C,V] = bits [3:0]
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_flag_gen.sv
// Flag generator for the multiply result (combinational, zero latency).
// Ports: P = full 2*WIDTH signed product, S = set-flags enable,
//        Flag = incoming [N,Z,C,V], New_Flag = outgoing [N,Z,C,V].
module mul_flag_gen
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH-1:0] P,
    input  logic               S,
    input  logic [3:0]         Flag,
    output logic [3:0]         New_Flag
);

    // Upper half plus the result sign bit: the truncated result is a
    // faithful signed value only when all of these bits agree.
    logic [WIDTH:0] hi_bits;
    assign hi_bits = P[2*WIDTH-1:WIDTH-1];

    always_comb begin
        New_Flag = Flag;
        if (S) begin
            New_Flag[FLG_N] = P[WIDTH-1];
            New_Flag[FLG_Z] = (P[WIDTH-1:0] == '0);
            New_Flag[FLG_C] = Flag[FLG_C];
            New_Flag[FLG_V] = !((hi_bits == '0) || (&hi_bits));
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle signed multiplier: radix-2 shift-add over magnitudes, sign fixed at the end.
// Ports: clk/rst (async, active-high); start/In1/In2/S/Flag request inputs latched in IDLE;
//        busy (CALC/FIX), done (one-cycle pulse), Result (low WIDTH bits), New_Flag [N,Z,C,V].
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             S,
    input  logic [3:0]       Flag,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       New_Flag
);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]   mcand;      // |In1|
    logic [WIDTH-1:0]   mplier;     // |In2|, consumed LSB first
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               sign;
    logic               s_lat;
    logic [3:0]         flag_lat;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] prod;
    logic [3:0]         flag_nxt;
    logic               last_iter;

    // Unsigned magnitudes: -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is
    // exactly the right unsigned value.
    assign a_mag = In1[WIDTH-1] ? -In1 : In1;
    assign b_mag = In2[WIDTH-1] ? -In2 : In2;

    assign addend    = {{WIDTH{1'b0}}, mcand} << cnt;
    assign prod      = sign ? -acc : acc;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    mul_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .P        (prod),
        .S        (s_lat),
        .Flag     (flag_lat),
        .New_Flag (flag_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            s_lat    <= 1'b0;
            flag_lat <= '0;
            Result   <= '0;
            New_Flag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand    <= a_mag;
                        mplier   <= b_mag;
                        sign     <= In1[WIDTH-1] ^ In2[WIDTH-1];
                        s_lat    <= S;
                        flag_lat <= Flag;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + addend;
                    end
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: begin
                    Result   <= prod[WIDTH-1:0];
                    New_Flag <= flag_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

    localparam int W    = 32;
    localparam int LAT  = W + 1;   // posedges from the start edge to the edge that raises done
    localparam int PER  = W + 3;   // back-to-back start-to-start spacing in cycles
    localparam int MAXC = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  In1;
    logic [W-1:0]  In2;
    logic          S;
    logic [3:0]    Flag;
    logic          busy;
    logic          done;
    logic [W-1:0]  Result;
    logic [3:0]    New_Flag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .In1      (In1),
        .In2      (In2),
        .S        (S),
        .Flag     (Flag),
        .busy     (busy),
        .done     (done),
        .Result   (Result),
        .New_Flag (New_Flag)
    );

    // Reference: full-precision signed product, truncation and flag rules.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  input logic [3:0] f, output logic [31:0] r, output logic [3:0] nf);
        longint pa, pb, p;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        r  = p[31:0];
        if (!s) begin
            nf = f;
        end else begin
            nf[3] = r[31];
            nf[2] = (r == 32'd0);
            nf[1] = f[1];
            nf[0] = (p != longint'($signed(r)));
        end
    endfunction

    // Drives one operation starting at the current negedge; returns at the
    // negedge of the cycle after done (the first cycle a new start is accepted).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] f,
                         output int lat, output int busy_n, output logic [31:0] res,
                         output logic [3:0] nf, output logic held, output logic done_next);
        logic [31:0] pre_r;
        logic [3:0]  pre_f;
        In1 = a; In2 = b; S = s; Flag = f; start = 1'b1;
        pre_r = Result; pre_f = New_Flag;
        lat = -1; busy_n = 0; held = 1'b1; res = 'x; nf = 'x; done_next = 1'bx;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= MAXC; n++) begin
            if (done) begin
                lat = n - 1;
                res = Result;
                nf  = New_Flag;
                break;
            end
            if (busy) busy_n++;
            if (Result !== pre_r || New_Flag !== pre_f) held = 1'b0;
            // scramble inputs while busy; they must have no effect
            In1 = $urandom; In2 = $urandom; S = 1'($urandom); Flag = 4'($urandom);
            start = 1'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
        @(negedge clk);
        done_next = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; In1 = '0; In2 = '0; S = 1'b0; Flag = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (Result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", Result); end
        n_checks++; if (New_Flag !== 4'b0) begin n_fail++; $display("FAIL reset_flag: got %b expected 0000", New_Flag); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ta [7] = '{32'd2, 32'd1, 32'hFFFFFFFA, 32'd0, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] tb [7] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd0, 32'd2, 32'hFFFFFFFF, 32'h80000000};
        logic        ts [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0]  tf [7] = '{4'b0000, 4'b0010, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        logic [31:0] er [7] = '{32'd6, 32'hFFFFFFFD, 32'd12, 32'd0, 32'hFFFFFFFE, 32'h80000000, 32'd0};
        logic [3:0]  ef [7] = '{4'b0000, 4'b1010, 4'b1111, 4'b0100, 4'b1001, 4'b1001, 4'b0111};
        int lat, bn; logic [31:0] r; logic [3:0] nf; logic held, dn;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], ts[i], tf[i], lat, bn, r, nf, held, dn);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT); end
            n_checks++; if (bn != LAT) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bn, LAT); end
            n_checks++; if (r !== er[i]) begin n_fail++; $display("FAIL dir%0d_result: got %h expected %h", i, r, er[i]); end
            n_checks++; if (nf !== ef[i]) begin n_fail++; $display("FAIL dir%0d_flags: got %b expected %b", i, nf, ef[i]); end
            n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL dir%0d_hold: got %b expected 1", i, held); end
            n_checks++; if (dn !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, dn); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn; logic [31:0] r, er; logic [3:0] nf, ef; logic held, dn;
        logic [31:0] a, b; logic s; logic [3:0] f;
        time t_prev, t_now;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom_range(0, 1000); s = 1'b1; f = 4'($urandom);
            t_now = $time;
            if (i > 0) begin
                n_checks++;
                if ((t_now - t_prev) != PER * 10) begin
                    n_fail++; $display("FAIL b2b%0d_period: got %0t expected %0d cycles", i, t_now - t_prev, PER);
                end
            end
            t_prev = t_now;
            do_op(a, b, s, f, lat, bn, r, nf, held, dn);
            model(a, b, s, f, er, ef);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b%0d_latency: got %0d expected %0d", i, lat, LAT); end
            n_checks++; if (r !== er) begin n_fail++; $display("FAIL b2b%0d_result: got %h expected %h", i, r, er); end
            n_checks++; if (nf !== ef) begin n_fail++; $display("FAIL b2b%0d_flags: got %b expected %b", i, nf, ef); end
        end
    endtask

    task automatic test_ignore_start();
        int dones, done_at, busy_after;
        logic [31:0] r1;
        dones = 0; done_at = -1; busy_after = 0; r1 = '0;
        In1 = 32'd10; In2 = 32'd10; S = 1'b0; Flag = 4'b0; start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 60; n++) begin
            start = 1'b0;
            if (n == 10) begin start = 1'b1; In1 = 32'd5; In2 = 32'd3; end
            if (done) begin
                dones++;
                if (done_at < 0) begin
                    done_at = n; r1 = Result;
                    start = 1'b1; In1 = 32'd7;     // start during DONE: must be ignored
                end
            end
            if (done_at > 0 && n > done_at && busy) busy_after++;
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", dones); end
        n_checks++; if (done_at - 1 != LAT) begin n_fail++; $display("FAIL ign_latency: got %0d expected %0d", done_at - 1, LAT); end
        n_checks++; if (r1 !== 32'd100) begin n_fail++; $display("FAIL ign_result: got %h expected %h", r1, 32'd100); end
        n_checks++; if (busy_after != 0) begin n_fail++; $display("FAIL ign_start_in_done: got %0d busy cycles expected 0", busy_after); end
        n_checks++; if (Result !== 32'd100) begin n_fail++; $display("FAIL ign_result_hold: got %h expected %h", Result, 32'd100); end
    endtask

    task automatic test_reset_mid();
        int dones, lat, bn; logic [31:0] r; logic [3:0] nf; logic held, dn;
        dones = 0;
        In1 = 32'd10; In2 = 32'd10; S = 1'b1; Flag = 4'b1111; start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 60; n++) begin
            start = 1'b0;
            if (n == 15) begin
                rst = 1'b1;
                #1;
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
                n_checks++; if (Result !== '0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 0", Result); end
                n_checks++; if (New_Flag !== 4'b0) begin n_fail++; $display("FAIL rstmid_flag: got %b expected 0000", New_Flag); end
            end
            if (n == 17) rst = 1'b0;
            if (done) dones++;
            @(negedge clk);
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", dones); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 0", busy); end
        do_op(32'd9, 32'hFFFFFFFF, 1'b0, 4'b0000, lat, bn, r, nf, held, dn);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rstmid_new_latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (r !== 32'hFFFFFFF7) begin n_fail++; $display("FAIL rstmid_new_result: got %h expected %h", r, 32'hFFFFFFF7); end
    endtask

    task automatic test_random();
        logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00010000};
        int lat, bn; logic [31:0] r, er, a, b; logic [3:0] nf, ef, f; logic held, dn, s;
        for (int i = 0; i < 25; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = $urandom_range(0, 255);
            s = 1'($urandom); f = 4'($urandom);
            do_op(a, b, s, f, lat, bn, r, nf, held, dn);
            model(a, b, s, f, er, ef);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, LAT); end
            n_checks++; if (r !== er) begin n_fail++; $display("FAIL rnd%0d_result: %h*%h got %h expected %h", i, a, b, r, er); end
            n_checks++; if (nf !== ef) begin n_fail++; $display("FAIL rnd%0d_flags: %h*%h got %b expected %b", i, a, b, nf, ef); end
            n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_hold: got %b expected 1", i, held); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
